// File: rtl/fm_pkg.sv
// fm_pkg: shared constants for the FM RSSI scan controller.
//   FM_HW_STATE_* : mode codes presented to the demod/RSSI engine
//   FM_RSSI_RDADDR: demod register holding the RSSI accumulator result
//   RSSI_W        : width of an RSSI measurement
//   scan_state_e  : scan sequencer state encoding
package fm_pkg;

  localparam logic [3:0] FM_HW_STATE_IDLE      = 4'b0000;
  localparam logic [3:0] FM_HW_STATE_RSSI      = 4'b0100;
  localparam logic [3:0] FM_HW_STATE_RSSI_DONE = 4'b1000;
  localparam logic [5:0] FM_RSSI_RDADDR        = 6'h14;
  localparam int         RSSI_W                = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_READ1   = 3'd3,
    ST_READ2   = 3'd4,
    ST_STORE   = 3'd5,
    ST_NEXT    = 3'd6,
    ST_FINISH  = 3'd7
  } scan_state_e;

endpackage

// File: rtl/fm_rssi_peak_track.sv
// fm_rssi_peak_track: remembers the strongest RSSI point of a scan.
//   clk, RSTn    : clock, async active-low reset
//   clear        : drop the recorded peak (new scan)
//   store        : a point is being written this cycle
//   point_valid  : the point was really measured (not a timeout)
//   value, freq  : RSSI and LO word of the point being stored
//   best_*       : recorded peak and whether one exists
module fm_rssi_peak_track
  import fm_pkg::*;
#(
  parameter int FREQ_W = 16
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              clear,
  input  logic              store,
  input  logic              point_valid,
  input  logic [RSSI_W-1:0] value,
  input  logic [FREQ_W-1:0] freq,
  output logic [FREQ_W-1:0] best_freq,
  output logic [RSSI_W-1:0] best_rssi,
  output logic              best_valid
);

  logic [FREQ_W-1:0] best_freq_q, best_freq_d;
  logic [RSSI_W-1:0] best_rssi_q, best_rssi_d;
  logic              best_valid_q, best_valid_d;
  logic              update;

  // Strictly-greater compare keeps the earliest point on ties; the first
  // real measurement is taken even when it reads zero.
  assign update = store && ((value > best_rssi_q) || (!best_valid_q && point_valid));

  always_comb begin
    best_freq_d  = best_freq_q;
    best_rssi_d  = best_rssi_q;
    best_valid_d = best_valid_q;
    if (clear) begin
      best_freq_d  = '0;
      best_rssi_d  = '0;
      best_valid_d = 1'b0;
    end else if (update) begin
      best_freq_d  = freq;
      best_rssi_d  = value;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      best_freq_q  <= '0;
      best_rssi_q  <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_freq_q  <= best_freq_d;
      best_rssi_q  <= best_rssi_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_freq  = best_freq_q;
  assign best_rssi  = best_rssi_q;
  assign best_valid = best_valid_q;

endmodule

// File: rtl/fm_rssi_scan_ctrl.sv
// fm_rssi_scan_ctrl: steps the LO across a band, measures RSSI per point,
// writes each result to a RAM port and tracks the strongest point.
//   start/abort            : firmware control pulses
//   freq_start/freq_step/num_steps : band description, latched on start
//   rssi_interrupt/rssi_rdata      : RSSI engine done and demod read data
//   FM_HW_state/rdaddr/lo_freq     : engine mode, demod read address, LO word
//   res_we/res_addr/res_wdata      : result RAM write port
//   best_freq/best_rssi/best_valid : strongest point of the scan
//   busy/done/timeout_err          : scan status
//
// state   | meaning
// IDLE    | waiting for start
// SETTLE  | PLL settle + accumulator clear (RSSI_DONE mode)
// MEASURE | accumulating, wait for interrupt or timeout
// READ1/2 | demod register read of the result
// STORE   | write result RAM, update peak
// NEXT    | advance index / LO word
// FINISH  | one-cycle done pulse
module fm_rssi_scan_ctrl
  import fm_pkg::*;
#(
  parameter int FM_ADDR_WIDTH  = 6,
  parameter int FREQ_W         = 16,
  parameter int STEP_W         = 8,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FREQ_W-1:0]        freq_start,
  input  logic [FREQ_W-1:0]        freq_step,
  input  logic [STEP_W-1:0]        num_steps,
  input  logic                     rssi_interrupt,
  input  logic [31:0]              rssi_rdata,
  output logic [3:0]               FM_HW_state,
  output logic [FM_ADDR_WIDTH-1:0] rdaddr,
  output logic [FREQ_W-1:0]        lo_freq,
  output logic                     res_we,
  output logic [STEP_W-1:0]        res_addr,
  output logic [RSSI_W-1:0]        res_wdata,
  output logic [FREQ_W-1:0]        best_freq,
  output logic [RSSI_W-1:0]        best_rssi,
  output logic                     best_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);

  scan_state_e       state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic [STEP_W-1:0] num_q, num_d;
  logic [FREQ_W-1:0] step_q, step_d;
  logic [FREQ_W-1:0] lo_q, lo_d;
  logic [RSSI_W-1:0] value_q, value_d;
  logic              tmo_pt_q, tmo_pt_d;
  logic              terr_q, terr_d;
  logic              peak_clear;
  logic              in_scan;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = ^rssi_rdata[31:RSSI_W];
  assign in_scan = (state_q != ST_IDLE) && (state_q != ST_FINISH);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    num_d      = num_q;
    step_d     = step_q;
    lo_d       = lo_q;
    value_d    = value_q;
    tmo_pt_d   = tmo_pt_q;
    terr_d     = terr_q;
    peak_clear = 1'b0;
    // Abort freezes all scan bookkeeping; only the state moves.
    if (abort && in_scan) begin
      state_d = ST_FINISH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_d      = num_steps;
            step_d     = freq_step;
            lo_d       = freq_start;
            idx_d      = '0;
            terr_d     = 1'b0;
            peak_clear = 1'b1;
            tmr_d      = SETTLE_LD;
            state_d    = (num_steps == '0) ? ST_FINISH : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == '0) begin
            tmr_d   = TIMEOUT_LD;
            state_d = ST_MEASURE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rssi_interrupt) begin
            tmo_pt_d = 1'b0;
            state_d  = ST_READ1;
          end else if (tmr_q == '0) begin
            tmo_pt_d = 1'b1;
            terr_d   = 1'b1;
            value_d  = '0;
            state_d  = ST_STORE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        ST_READ1: state_d = ST_READ2;
        ST_READ2: begin
          value_d = rssi_rdata[RSSI_W-1:0];
          state_d = ST_STORE;
        end
        ST_STORE: state_d = ST_NEXT;
        ST_NEXT: begin
          idx_d = idx_q + 1'b1;
          if (STEP_W'(idx_q + 1'b1) == num_q) begin
            state_d = ST_FINISH;
          end else begin
            lo_d    = lo_q + step_q;
            tmr_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      step_q   <= '0;
      lo_q     <= '0;
      value_q  <= '0;
      tmo_pt_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      step_q   <= step_d;
      lo_q     <= lo_d;
      value_q  <= value_d;
      tmo_pt_q <= tmo_pt_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    FM_HW_state = FM_HW_STATE_IDLE;
    case (state_q)
      ST_SETTLE:                                        FM_HW_state = FM_HW_STATE_RSSI_DONE;
      ST_MEASURE, ST_READ1, ST_READ2, ST_STORE, ST_NEXT: FM_HW_state = FM_HW_STATE_RSSI;
      default:                                          FM_HW_state = FM_HW_STATE_IDLE;
    endcase
  end

  assign rdaddr      = ((state_q == ST_READ1) || (state_q == ST_READ2)) ?
                       FM_ADDR_WIDTH'(FM_RSSI_RDADDR) : '0;
  assign res_we      = (state_q == ST_STORE) && !abort;
  assign res_addr    = idx_q;
  assign res_wdata   = value_q;
  assign lo_freq     = lo_q;
  assign busy        = in_scan;
  assign done        = (state_q == ST_FINISH);
  assign timeout_err = terr_q;

  fm_rssi_peak_track #(.FREQ_W(FREQ_W)) u_peak (
    .clk         (clk),
    .RSTn        (RSTn),
    .clear       (peak_clear),
    .store       (res_we),
    .point_valid (!tmo_pt_q),
    .value       (value_q),
    .freq        (lo_q),
    .best_freq   (best_freq),
    .best_rssi   (best_rssi),
    .best_valid  (best_valid)
  );

endmodule

// File: tb/tb_fm_rssi_scan_ctrl.sv
// tb_fm_rssi_scan_ctrl: drives band scans against an RSSI engine model and
// compares RAM writes, LO words, protocol timing and peak results with a
// reference computed from the scan rules.
module tb_fm_rssi_scan_ctrl;
  import fm_pkg::*;

  localparam int SETTLE = 256;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] freq_start = '0;
  logic [15:0] freq_step = '0;
  logic [7:0]  num_steps = '0;
  logic        rssi_interrupt = 1'b0;
  logic [31:0] rssi_rdata = '0;
  logic [3:0]  FM_HW_state;
  logic [5:0]  rdaddr;
  logic [15:0] lo_freq;
  logic        res_we;
  logic [7:0]  res_addr;
  logic [16:0] res_wdata;
  logic [15:0] best_freq;
  logic [16:0] best_rssi;
  logic        best_valid;
  logic        busy;
  logic        done;
  logic        timeout_err;

  always #5 clk = ~clk;

  fm_rssi_scan_ctrl #(
    .FM_ADDR_WIDTH(6), .FREQ_W(16), .STEP_W(8),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .abort(abort),
    .freq_start(freq_start), .freq_step(freq_step), .num_steps(num_steps),
    .rssi_interrupt(rssi_interrupt), .rssi_rdata(rssi_rdata),
    .FM_HW_state(FM_HW_state), .rdaddr(rdaddr), .lo_freq(lo_freq),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
    .best_freq(best_freq), .best_rssi(best_rssi), .best_valid(best_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Per-point engine behaviour for the current scan.
  logic [16:0] pt_val[64];
  bit          pt_tmo[64];
  int          pt_dly[64];
  int          abort_idx = -1;

  // Engine model state.
  int          eng_pt = -1;
  int          meas_cnt = 0;
  logic [3:0]  prev_hw = 4'b0000;
  bit          abort_sent = 0;
  int          abort_cyc = 0;
  int          cyc = 0;

  // Monitor state and expected-write queues.
  bit          mon_en = 1;
  int          settle_run = 0;
  int          read_run = 0;
  int          done_cnt = 0;
  logic [7:0]  ex_addr[$];
  logic [16:0] ex_data[$];
  logic [15:0] ex_freq[$];

  task automatic engine_step();
    int p;
    abort = 1'b0;
    if (!RSTn || !busy) begin
      rssi_interrupt = 1'b0;
      eng_pt = -1;
      meas_cnt = 0;
      abort_sent = 0;
    end else if (FM_HW_state == 4'b1000) begin
      if (prev_hw != 4'b1000) eng_pt++;
      meas_cnt = 0;
      rssi_interrupt = 1'b0;
    end else if (FM_HW_state == 4'b0100) begin
      p = (eng_pt < 0) ? 0 : eng_pt;
      if (rdaddr == 6'h00 && p == abort_idx && meas_cnt == 3 && !abort_sent) begin
        abort = 1'b1;
        abort_sent = 1;
        abort_cyc = cyc;
      end
      if (!pt_tmo[p] && p != abort_idx && meas_cnt == pt_dly[p]) rssi_interrupt = 1'b1;
      meas_cnt++;
    end
    p = (eng_pt < 0) ? 0 : eng_pt;
    if (rdaddr == 6'h14) rssi_rdata = {15'($urandom), pt_val[p]};
    else                 rssi_rdata = $urandom;
    prev_hw = FM_HW_state;
  endtask

  task automatic monitor_step();
    if (!mon_en) return;
    if (FM_HW_state == 4'b1000) settle_run++;
    else begin
      if (settle_run != 0) begin
        check("settle_len", settle_run, SETTLE);
        check("hw_after_settle", FM_HW_state, 4'b0100);
      end
      settle_run = 0;
    end
    if (rdaddr != 6'h00) begin
      read_run++;
      check("rdaddr_val", rdaddr, 6'h14);
      check("rdaddr_hw", FM_HW_state, 4'b0100);
    end else begin
      if (read_run != 0) check("read_len", read_run, 2);
      read_run = 0;
    end
    if (res_we) begin
      if (ex_addr.size() == 0) check("unexpected_we", 1, 0);
      else begin
        check("res_addr", res_addr, ex_addr.pop_front());
        check("res_wdata", res_wdata, ex_data.pop_front());
        check("lo_freq", lo_freq, ex_freq.pop_front());
      end
    end
    if (done) done_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    engine_step();
    monitor_step();
  endtask

  task automatic set_pt(input int i, input logic [16:0] v, input bit t);
    pt_val[i] = v;
    pt_tmo[i] = t;
    pt_dly[i] = $urandom_range(0, 60);
  endtask

  task automatic run_scan(input logic [15:0] fs, input logic [15:0] st, input int n,
                          input int abort_at, input bit with_abort);
    bit          m_valid;
    logic [16:0] m_best;
    logic [15:0] m_freq;
    bit          m_terr;
    int          nw, k, bound;
    logic [15:0] f;
    m_valid = 0; m_best = '0; m_freq = '0; m_terr = 0;
    nw = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < nw; i++) begin
      f = fs + 16'(i * st);
      ex_addr.push_back(8'(i));
      ex_data.push_back(pt_tmo[i] ? 17'd0 : pt_val[i]);
      ex_freq.push_back(f);
      if (!pt_tmo[i] && (!m_valid || pt_val[i] > m_best)) begin
        m_valid = 1; m_best = pt_val[i]; m_freq = f;
      end
      if (pt_tmo[i]) m_terr = 1;
    end
    abort_idx = abort_at;
    done_cnt = 0;
    freq_start = fs; freq_step = st; num_steps = 8'(n);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    freq_start = $urandom; freq_step = $urandom; num_steps = $urandom;
    if (n > 0) begin
      repeat (10) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      check("zero_done_next", done, 1);
    end
    bound = n * (SETTLE + TMO + 20) + 50;
    k = 0;
    while (!done && k < bound) begin
      tick();
      k++;
    end
    if (!done) check("done_wait_expired", 0, 1);
    else begin
      check("fin_busy", busy, 0);
      check("fin_hw", FM_HW_state, 4'b0000);
      check("fin_rdaddr", rdaddr, 6'h00);
      check("best_valid", best_valid, m_valid);
      check("best_rssi", best_rssi, m_best);
      check("best_freq", best_freq, m_freq);
      check("timeout_err", timeout_err, m_terr);
      check("writes_left", ex_addr.size(), 0);
      if (abort_at >= 0) check("abort_latency", cyc - abort_cyc, 1);
    end
    tick();
    check("done_pulses", done_cnt, 1);
    check("done_low", done, 0);
    ex_addr.delete(); ex_data.delete(); ex_freq.delete();
    abort_idx = -1;
    repeat (3) tick();
  endtask

  initial begin
    #2;
    check("rst_hw", FM_HW_state, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", lo_freq, 0);
    check("rst_best", {best_valid, best_rssi}, 0);
    repeat (2) tick();
    RSTn = 1'b1;
    repeat (2) tick();

    // Basic three-point scan.
    set_pt(0, 17'h00100, 0); set_pt(1, 17'h1F000, 0); set_pt(2, 17'h00080, 0);
    run_scan(16'd1000, 16'd50, 3, -1, 0);

    // Timeout on the second of two points.
    set_pt(0, 17'h00333, 0); set_pt(1, 17'h1FFFF, 1);
    run_scan(16'd200, 16'd7, 2, -1, 0);

    // Equal RSSI with LO wrap, started together with an idle abort.
    set_pt(0, 17'h00500, 0); set_pt(1, 17'h00500, 0);
    run_scan(16'hFFF0, 16'h0020, 2, -1, 1);

    // Abort during measure of the third point, then a full rerun.
    for (int i = 0; i < 5; i++) set_pt(i, 17'($urandom), 0);
    run_scan(16'h1234, 16'h0100, 5, 2, 0);
    run_scan(16'h1234, 16'h0100, 5, -1, 0);

    // Empty band.
    run_scan(16'h4000, 16'h0001, 0, -1, 0);

    // Randomised scans with duplicate values and random timeouts.
    for (int s = 0; s < 4; s++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        set_pt(i, (i > 0 && $urandom_range(0, 2) == 0) ? pt_val[i-1] : 17'($urandom),
               $urandom_range(0, 4) == 0);
      run_scan(16'($urandom), 16'($urandom), n, -1, 0);
    end

    // Async reset in the middle of a settle interval.
    set_pt(0, 17'h00010, 0); set_pt(1, 17'h00020, 0); set_pt(2, 17'h00030, 0);
    freq_start = 16'h0777; freq_step = 16'h0011; num_steps = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("pre_rst_hw", FM_HW_state, 4'b1000);
    mon_en = 0;
    #2 RSTn = 1'b0;
    #1;
    check("mid_rst_hw", FM_HW_state, 4'b0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lo", lo_freq, 0);
    check("mid_rst_we", {res_we, res_addr, res_wdata}, 0);
    check("mid_rst_best", {best_valid, best_freq, best_rssi}, 0);
    check("mid_rst_flags", {done, timeout_err, rdaddr}, 0);
    tick();
    RSTn = 1'b1;
    repeat (5) tick();
    check("post_rst_busy", busy, 0);
    settle_run = 0; read_run = 0;
    mon_en = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_rssi_scan_ctrl.md
Name: fm_rssi_scan_ctrl

Overview:
Sequencer that drives the FM RSSI scan engine from the initiator side. It steps the LO frequency word across a programmed band and, for each point, clears and then arms the RSSI accumulator. It waits for the RSSI interrupt, reads the 17-bit result over the demod register bus, and stores it to a result RAM port. It also tracks the strongest channel, letting firmware trigger one full band scan and read back best_freq and best_rssi.

Parameters:
FM_ADDR_WIDTH, 6, width of demod register read address
FREQ_W, 16, LO frequency word width
STEP_W, 8, width of step count and result RAM address
SETTLE_CYCLES, 256, clk cycles FM_HW_state is held at RSSI_DONE after retune (PLL settle plus accumulator clear)
TIMEOUT_CYCLES, 1048576, max clk cycles waiting for rssi_interrupt per step

Ports:
clk  in  1  system clock
RSTn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins scan when idle
abort  in  1  single-cycle pulse; terminates scan
freq_start  in  FREQ_W  first LO word
freq_step  in  FREQ_W  LO increment per step
num_steps  in  STEP_W  number of points to measure
rssi_interrupt  in  1  done pulse/level from RSSI scan engine
rssi_rdata  in  32  registered read data from demod bus
FM_HW_state  out  4  mode to demod/RSSI engine
rdaddr  out  FM_ADDR_WIDTH  demod register read address
lo_freq  out  FREQ_W  LO frequency word to synthesizer
res_we  out  1  result RAM write strobe
res_addr  out  STEP_W  result RAM address (step index)
res_wdata  out  17  RSSI value written
best_freq  out  FREQ_W  LO word of strongest point
best_rssi  out  17  strongest RSSI value
best_valid  out  1  at least one valid point recorded
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion or abort
timeout_err  out  1  sticky; any step timed out this scan

Behaviour:
- Reset (RSTn low, async): FSM=IDLE; FM_HW_state=4'b0000; rdaddr=0; lo_freq=0; res_we=0; res_addr=0; res_wdata=0; best_*=0; best_valid=0; busy=0; done=0; timeout_err=0.
- All logic in the clk domain; rssi_interrupt is sampled as a level in MEASURE only.
- IDLE: FM_HW_state=IDLE. On start, latch freq_start/freq_step/num_steps; clear best_*, best_valid, timeout_err; idx=0; lo_freq=freq_start; busy=1. If num_steps==0, go to FINISH; otherwise go to SETTLE.
- SETTLE: FM_HW_state=RSSI_DONE (4'b1000) for exactly SETTLE_CYCLES clk, then MEASURE.
- MEASURE: FM_HW_state=RSSI (4'b0100); timer counts up.
  - rssi_interrupt high: go to READ.
  - Timer reaches TIMEOUT_CYCLES with interrupt low: set timeout_err, set value=0, go to STORE (skip READ).
- READ (2 cycles): FM_HW_state stays RSSI; rdaddr=6'h14 in both cycles; capture value=rssi_rdata[16:0] at the end of the 2nd cycle; go to STORE.
- STORE (1 cycle): res_we=1, res_addr=idx, res_wdata=value.
  - If value > best_rssi, or best_valid==0 and not a timed-out point: update best_rssi, best_freq=lo_freq, best_valid=1.
  - Ties keep the earlier (lower idx) point.
  - Then go to NEXT.
- NEXT: idx+1; if idx+1==num_steps go to FINISH; otherwise lo_freq += freq_step (mod 2^FREQ_W, wraps silently) and go to SETTLE.
- FINISH: done=1 for one cycle; busy=0; FM_HW_state=IDLE; rdaddr=0; go to IDLE. best_*, best_valid and timeout_err hold until the next start.
- abort in any non-IDLE state: go to FINISH next cycle; no RAM write that cycle; best_* keep their partial values.
  - abort in IDLE is ignored.
  - abort and start in the same cycle in IDLE: start wins.
- start while busy is ignored.
- Inputs freq_*/num_steps changing mid-scan have no effect.
- res_we is only ever high in STORE.
- rdaddr=0 outside READ.

Decomposition:
- Package fm_pkg: FM_HW_STATE_IDLE=4'b0000, FM_HW_STATE_RSSI=4'b0100, FM_HW_STATE_RSSI_DONE=4'b1000, FM_RSSI_RDADDR=6'h14, RSSI_W=17, and the FSM state encoding.
- One sub-module, fm_rssi_peak_track: holds best_rssi/best_freq/best_valid and does compare/update on the store strobe; has a clear input.

Test Plan:
- Basic 3-point scan: freq_start=1000, freq_step=50, num_steps=3; engine model returns 0x100, 0x1F000, 0x80 -> 3 RAM writes at addr 0,1,2 with matching data; lo_freq sequence 1000,1050,1100; best_freq=1050, best_rssi=0x1F000, done pulses once.
- Protocol timing: check FM_HW_state=4'b1000 for exactly 256 cycles before each 4'b0100 interval; rdaddr=0x14 only during the 2 READ cycles.
- Timeout: engine never interrupts on step 1 of 2, TIMEOUT_CYCLES=100 for test -> res_wdata=0 at addr 1, timeout_err=1, best taken from step 0.
- Ties and wrap: freq_start=16'hFFF0, freq_step=16'h20, equal RSSI 0x500 both points -> lo_freq goes to 16'h0010; best_freq=16'hFFF0.
- Abort mid-MEASURE on step 2 of 5 -> done next cycle, busy=0, FM_HW_state=0, only 2 RAM writes; restart then runs a full 5-point scan.
- num_steps=0 -> done one cycle after start, no RAM writes, best_valid=0; async reset asserted mid-SETTLE -> all outputs return to reset values immediately.
